// File: rtl/mac_dot_ctrl_pkg.sv
// Shared definitions for the streamed dot-product sequencer: state encoding
// and default datapath widths.
package mac_dot_ctrl_pkg;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int LEN_BW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mac_dot_ctrl_if.sv
// Command, operand-stream and result handshakes of the dot-product sequencer.
// The master side feeds commands/operands and drains results.
interface mac_dot_ctrl_if
    import mac_dot_ctrl_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int len_bw  = LEN_BW
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [len_bw-1:0]   cmd_len;
    logic                cmd_acc;
    logic                in_valid;
    logic                in_ready;
    logic [bw-1:0]       in_a;
    logic [bw-1:0]       in_b;
    logic                out_valid;
    logic                out_ready;
    logic [psum_bw-1:0]  out_psum;
    logic                out_ovf;
    logic                busy;

    modport master (
        output cmd_valid, cmd_len, cmd_acc, in_valid, in_a, in_b, out_ready,
        input  cmd_ready, in_ready, out_valid, out_psum, out_ovf, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_acc, in_valid, in_a, in_b, out_ready,
        output cmd_ready, in_ready, out_valid, out_psum, out_ovf, busy
    );
endinterface

// File: rtl/mac_dot_ctrl_mac.sv
// Combinational multiply-accumulate: unsigned activation times signed weight,
// sign-extended (or wrapped) to the accumulator width and added to c.
module mac #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic [bw-1:0]      a,
    input  logic [bw-1:0]      b,
    input  logic [psum_bw-1:0] c,
    output logic [psum_bw-1:0] prod,
    output logic [psum_bw-1:0] out
);
    localparam int PW = 2 * bw + 1;

    logic signed [PW-1:0] a_ext_s;
    logic signed [PW-1:0] b_ext_s;
    logic signed [PW-1:0] prod_full_s;

    // The activation gets a zero sign bit so it multiplies as a non-negative value.
    assign a_ext_s     = PW'($signed({1'b0, a}));
    assign b_ext_s     = PW'($signed(b));
    assign prod_full_s = a_ext_s * b_ext_s;
    assign prod        = psum_bw'(prod_full_s);
    assign out         = c + prod;
endmodule

// File: rtl/mac_dot_ctrl.sv
// Sequencer that runs one mac over a streamed dot product of programmable
// length and hands the accumulated psum downstream with a valid/ready handshake.
module mac_dot_ctrl
    import mac_dot_ctrl_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int len_bw  = LEN_BW
) (
    input  logic           clk,
    input  logic           reset,
    mac_dot_ctrl_if.slave  bus
);
    state_e               state_q;
    logic [psum_bw-1:0]   acc_q;
    logic [len_bw-1:0]    cnt_q;
    logic [len_bw-1:0]    len_q;
    logic                 ovf_q;
    logic                 cmd_ready_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [psum_bw-1:0]   prod_s;
    logic [psum_bw-1:0]   mac_out_s;
    logic                 beat_s;
    logic                 ovf_beat_s;

    mac #(.bw(bw), .psum_bw(psum_bw)) u_mac (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .c    (acc_q),
        .prod (prod_s),
        .out  (mac_out_s)
    );

    assign beat_s     = bus.in_valid & in_ready_q;
    // Signed overflow: both addends share a sign the wrapped sum does not.
    assign ovf_beat_s = (prod_s[psum_bw-1] == acc_q[psum_bw-1]) &&
                        (mac_out_s[psum_bw-1] != acc_q[psum_bw-1]);

    // Control FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= {psum_bw{1'b0}};
            cnt_q       <= {len_bw{1'b0}};
            len_q       <= {len_bw{1'b0}};
            ovf_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        len_q       <= bus.cmd_len;
                        acc_q       <= bus.cmd_acc ? acc_q : {psum_bw{1'b0}};
                        ovf_q       <= 1'b0;
                        cnt_q       <= {len_bw{1'b0}};
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.cmd_len != {len_bw{1'b0}}) begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat_s) begin
                        acc_q <= mac_out_s;
                        ovf_q <= ovf_q | ovf_beat_s;
                        cnt_q <= cnt_q + len_bw'(1);
                        if (cnt_q == len_q - len_bw'(1)) begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_psum  = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Self-checking bench for mac_dot_ctrl: table-driven commands against a
// 16-bit instance plus hand-written reset and 8-bit overflow sequences.
module tb_mac_dot_ctrl;
    logic clk;
    logic reset;

    mac_dot_ctrl_if #(.bw(4), .psum_bw(16), .len_bw(8)) bus16 ();
    mac_dot_ctrl_if #(.bw(4), .psum_bw(8),  .len_bw(8)) bus8 ();

    mac_dot_ctrl #(.bw(4), .psum_bw(16), .len_bw(8)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    mac_dot_ctrl #(.bw(4), .psum_bw(8), .len_bw(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          len;
        bit          acc;
        int          a [4];
        int          b [4];
        int          gap;
        int          hold;
        logic [15:0] psum;
        bit          ovf;
    } vec_t;

    typedef struct {
        logic [15:0] psum;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        exp_t e;
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, bus16.cmd_ready}, 32'd1);
        bus16.cmd_valid = 1'b1;
        bus16.cmd_len   = 8'(v.len);
        bus16.cmd_acc   = v.acc;
        sb.push_back('{psum: v.psum, ovf: v.ovf});
        @(negedge clk);
        bus16.cmd_valid = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                bus16.in_valid = 1'b0;
                @(negedge clk);
            end
            chk("in_ready_run", {31'd0, bus16.in_ready}, 32'd1);
            bus16.in_valid = 1'b1;
            bus16.in_a     = 4'(v.a[i]);
            bus16.in_b     = 4'(v.b[i]);
            @(negedge clk);
            bus16.in_valid = 1'b0;
        end
        chk("out_valid_latency", {31'd0, bus16.out_valid}, 32'd1);
        for (int h = 0; h < v.hold; h++) begin
            chk("done_in_ready", {31'd0, bus16.in_ready}, 32'd0);
            chk("done_cmd_ready", {31'd0, bus16.cmd_ready}, 32'd0);
            chk("done_psum_stable", {16'd0, bus16.out_psum}, {16'd0, v.psum});
            @(negedge clk);
            chk("done_out_valid", {31'd0, bus16.out_valid}, 32'd1);
        end
        e = sb.pop_front();
        chk("out_psum", {16'd0, bus16.out_psum}, {16'd0, e.psum});
        chk("out_ovf", {31'd0, bus16.out_ovf}, {31'd0, e.ovf});
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        chk("idle_out_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("idle_busy", {31'd0, bus16.busy}, 32'd0);
    endtask

    task automatic beat8(input int a, input int b);
        bus8.in_valid = 1'b1;
        bus8.in_a     = 4'(a);
        bus8.in_b     = 4'(b);
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{len: 3, acc: 1'b0, a: '{3, 15, 4, 0}, b: '{2, -1, -8, 0},
                    gap: 0, hold: 0, psum: 16'hFFD7, ovf: 1'b0};
        vecs[1] = '{len: 3, acc: 1'b0, a: '{3, 15, 4, 0}, b: '{2, -1, -8, 0},
                    gap: 2, hold: 5, psum: 16'hFFD7, ovf: 1'b0};
        vecs[2] = '{len: 1, acc: 1'b1, a: '{1, 0, 0, 0}, b: '{1, 0, 0, 0},
                    gap: 0, hold: 1, psum: 16'hFFD8, ovf: 1'b0};
        vecs[3] = '{len: 0, acc: 1'b0, a: '{0, 0, 0, 0}, b: '{0, 0, 0, 0},
                    gap: 0, hold: 0, psum: 16'h0000, ovf: 1'b0};
        vecs[4] = '{len: 4, acc: 1'b0, a: '{15, 15, 15, 15}, b: '{7, 7, 7, 7},
                    gap: 1, hold: 2, psum: 16'h01A4, ovf: 1'b0};
        vecs[5] = '{len: 2, acc: 1'b1, a: '{0, 8, 0, 0}, b: '{-8, -8, 0, 0},
                    gap: 0, hold: 0, psum: 16'h0164, ovf: 1'b0};

        bus16.cmd_valid = 1'b0; bus16.cmd_len = 8'd0; bus16.cmd_acc = 1'b0;
        bus16.in_valid  = 1'b0; bus16.in_a = 4'd0; bus16.in_b = 4'd0;
        bus16.out_ready = 1'b0;
        bus8.cmd_valid  = 1'b0; bus8.cmd_len = 8'd0; bus8.cmd_acc = 1'b0;
        bus8.in_valid   = 1'b0; bus8.in_a = 4'd0; bus8.in_b = 4'd0;
        bus8.out_ready  = 1'b0;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, bus16.cmd_ready}, 32'd1);
        chk("rst_in_ready", {31'd0, bus16.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("rst_out_psum", {16'd0, bus16.out_psum}, 32'd0);
        chk("rst_out_ovf", {31'd0, bus16.out_ovf}, 32'd0);
        chk("rst_busy", {31'd0, bus16.busy}, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_cmd(vecs[k]);

        // 8-bit accumulator: 105 + 105 wraps to -46 and flags overflow.
        @(negedge clk);
        bus8.cmd_valid = 1'b1; bus8.cmd_len = 8'd2; bus8.cmd_acc = 1'b0;
        @(negedge clk);
        bus8.cmd_valid = 1'b0;
        beat8(15, 7);
        beat8(15, 7);
        chk("p8_out_valid", {31'd0, bus8.out_valid}, 32'd1);
        chk("p8_psum", {24'd0, bus8.out_psum}, 32'h0000_00D2);
        chk("p8_ovf", {31'd0, bus8.out_ovf}, 32'd1);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        chk("p8_cmd_ready", {31'd0, bus8.cmd_ready}, 32'd1);
        bus8.cmd_valid = 1'b1; bus8.cmd_len = 8'd1; bus8.cmd_acc = 1'b0;
        @(negedge clk);
        bus8.cmd_valid = 1'b0;
        beat8(1, 1);
        chk("p8_out_valid2", {31'd0, bus8.out_valid}, 32'd1);
        chk("p8_psum2", {24'd0, bus8.out_psum}, 32'd1);
        chk("p8_ovf_cleared", {31'd0, bus8.out_ovf}, 32'd0);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;

        // Reset in the middle of a run must discard the partial sum.
        bus16.cmd_valid = 1'b1; bus16.cmd_len = 8'd5; bus16.cmd_acc = 1'b0;
        @(negedge clk);
        bus16.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus16.in_valid = 1'b1; bus16.in_a = 4'd7; bus16.in_b = 4'd7;
            @(negedge clk);
        end
        bus16.in_valid = 1'b0;
        chk("pre_rst_acc", {16'd0, bus16.out_psum}, 32'd98);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_cmd_ready", {31'd0, bus16.cmd_ready}, 32'd1);
        chk("mid_rst_in_ready", {31'd0, bus16.in_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus16.busy}, 32'd0);
        chk("mid_rst_psum", {16'd0, bus16.out_psum}, 32'd0);
        run_cmd('{len: 1, acc: 1'b1, a: '{2, 0, 0, 0}, b: '{3, 0, 0, 0},
                  gap: 0, hold: 0, psum: 16'h0006, ovf: 1'b0});

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
